// File: rtl/mux_scan_ctrl.sv
// Scans a 16-bit word through an external 16:1 mux one select value at a time,
// capturing each mux output into a result word and a serial bit stream.
//
// state  | meaning
// IDLE   | waiting for start; all registers hold
// SETTLE | select stable, hold counter running down before the sample
// SAMPLE | capture mux_out for the current select, then advance
// DONE   | one-cycle completion pulse, returns to IDLE
module mux_scan_ctrl #(
  parameter int unsigned HOLD_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [0:15] data,
  output logic [0:15] mux_in,
  output logic [3:0]  mux_sel,
  input  logic        mux_out,
  output logic        ser_bit,
  output logic        ser_valid,
  output logic        busy,
  output logic        done,
  output logic [0:15] result,
  output logic        mismatch
);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  localparam logic [3:0] HOLD = 4'(HOLD_CYCLES);
  // With no settle time the FSM goes straight from select update to sampling.
  localparam state_t POST_SEL = (HOLD_CYCLES == 0) ? SAMPLE : SETTLE;

  state_t     state, state_nxt;
  logic [3:0] hold_cnt;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = POST_SEL;
      SETTLE:  if (hold_cnt <= 4'd1) state_nxt = SAMPLE;
      SAMPLE:  state_nxt = (mux_sel == 4'd15) ? DONE : POST_SEL;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    busy = (state != IDLE);
    done = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mux_in    <= '0;
      mux_sel   <= '0;
      ser_bit   <= 1'b0;
      ser_valid <= 1'b0;
      result    <= '0;
      mismatch  <= 1'b0;
      hold_cnt  <= '0;
    end else begin
      ser_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mux_in   <= data;
            mux_sel  <= '0;
            result   <= '0;
            mismatch <= 1'b0;
            hold_cnt <= HOLD;
          end
        end
        SETTLE: hold_cnt <= hold_cnt - 4'd1;
        SAMPLE: begin
          result[mux_sel] <= mux_out;
          ser_bit         <= mux_out;
          ser_valid       <= 1'b1;
          if (mux_out != mux_in[mux_sel]) mismatch <= 1'b1;
          // Select parks at 15 after the last bit so the final index stays visible.
          if (mux_sel != 4'd15) begin
            mux_sel  <= mux_sel + 4'd1;
            hold_cnt <= HOLD;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl: two instances (no settle time, two settle cycles),
// each with a behavioural 16:1 mux; expected serial stream queued per scan.
module tb_mux_scan_ctrl;

  logic        clk = 1'b0;
  int          cyc = 0;
  logic [1:0]  rst, start, force0;
  logic [0:15] data    [2];
  logic [0:15] mux_in  [2];
  logic [0:15] result  [2];
  logic [3:0]  mux_sel [2];
  logic [1:0]  mux_out, ser_bit, ser_valid, busy, done, mismatch;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int          inst;
    int          cyc;
    logic        bitv;
    logic        last;
    logic [0:15] res;
    logic        mm;
    logic [0:15] din;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mux_scan_ctrl #(.HOLD_CYCLES((g == 0) ? 0 : 2)) u_dut (
      .clk      (clk),
      .rst      (rst[g]),
      .start    (start[g]),
      .data     (data[g]),
      .mux_in   (mux_in[g]),
      .mux_sel  (mux_sel[g]),
      .mux_out  (mux_out[g]),
      .ser_bit  (ser_bit[g]),
      .ser_valid(ser_valid[g]),
      .busy     (busy[g]),
      .done     (done[g]),
      .result   (result[g]),
      .mismatch (mismatch[g])
    );
    assign mux_out[g] = force0[g] ? 1'b0 : mux_in[g][mux_sel[g]];
  end

  function automatic int hold_of(int g);
    return (g == 0) ? 0 : 2;
  endfunction

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", nm, act, exp, cyc);
    end
  endfunction

  // Expected stream: bit i of the scan appears (i+1)*(hold+1) cycles after the
  // accepting edge; result/mismatch accumulate as each bit lands.
  function automatic void push_scan(int g, int a, logic [0:15] d, logic f0, int nbits);
    exp_t        e;
    logic [0:15] res = '0;
    logic        mm  = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      logic b;
      b      = f0 ? 1'b0 : d[i];
      res[i] = b;
      if (b != d[i]) mm = 1'b1;
      e.inst = g;
      e.cyc  = a + (i + 1) * (hold_of(g) + 1);
      e.bitv = b;
      e.last = (i == 15);
      e.res  = res;
      e.mm   = mm;
      e.din  = d;
      q.push_back(e);
    end
  endfunction

  always @(negedge clk) begin
    exp_t e;
    for (int g = 0; g < 2; g++) begin
      if (ser_valid[g]) begin
        if (q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL spurious_valid inst %0d: got ser_valid=1 expected none (cyc %0d)", g, cyc);
        end else begin
          e = q.pop_front();
          chk("valid_inst", 32'(g), 32'(e.inst));
          chk("valid_cyc", 32'(cyc), 32'(e.cyc));
          chk("ser_bit", 32'(ser_bit[g]), 32'(e.bitv));
          chk("done", 32'(done[g]), 32'(e.last));
          chk("result", 32'(result[g]), 32'(e.res));
          chk("mismatch", 32'(mismatch[g]), 32'(e.mm));
          chk("mux_in", 32'(mux_in[g]), 32'(e.din));
          chk("busy_in_scan", 32'(busy[g]), 32'd1);
        end
      end else if (done[g]) begin
        n_tests++;
        n_fail++;
        $display("FAIL done_unqualified inst %0d: got done=1 expected ser_valid with it (cyc %0d)", g, cyc);
      end
    end
  end

  task automatic check_zero(int g, string tag);
    chk({tag, "_busy"}, 32'(busy[g]), 32'd0);
    chk({tag, "_done"}, 32'(done[g]), 32'd0);
    chk({tag, "_ser_valid"}, 32'(ser_valid[g]), 32'd0);
    chk({tag, "_ser_bit"}, 32'(ser_bit[g]), 32'd0);
    chk({tag, "_result"}, 32'(result[g]), 32'd0);
    chk({tag, "_mismatch"}, 32'(mismatch[g]), 32'd0);
    chk({tag, "_mux_in"}, 32'(mux_in[g]), 32'd0);
    chk({tag, "_mux_sel"}, 32'(mux_sel[g]), 32'd0);
  endtask

  // Called at a negedge; start is accepted at the following edge.
  task automatic run_scan(int g, logic [0:15] d, logic f0, bit glitch, bit midchange);
    int          a, dn;
    logic [0:15] res;
    a  = cyc + 1;
    dn = a + 16 * (hold_of(g) + 1);
    force0[g] = f0;
    data[g]   = d;
    push_scan(g, a, d, f0, 16);
    start[g] = 1'b1;
    @(negedge clk);
    while (cyc < dn + 2) begin
      start[g] = (glitch && cyc < dn) ? ($urandom_range(0, 2) == 0) : 1'b0;
      if (midchange && cyc == a + 4) data[g] = ~d;
      @(negedge clk);
    end
    start[g] = 1'b0;
    res = '0;
    for (int i = 0; i < 16; i++) res[i] = f0 ? 1'b0 : d[i];
    chk("post_qempty", 32'(q.size()), 32'd0);
    chk("post_sel", 32'(mux_sel[g]), 32'd15);
    chk("post_result", 32'(result[g]), 32'(res));
    chk("post_mux_in", 32'(mux_in[g]), 32'(d));
    chk("post_mismatch", 32'(mismatch[g]), 32'(res != d));
    chk("post_busy", 32'(busy[g]), 32'd0);
    chk("post_valid", 32'(ser_valid[g]), 32'd0);
  endtask

  initial begin
    int a, busy_low;
    rst     = 2'b11;
    start   = 2'b00;
    force0  = 2'b00;
    data[0] = '0;
    data[1] = '0;
    repeat (3) @(negedge clk);
    check_zero(0, "reset0");
    check_zero(1, "reset1");
    rst = 2'b00;
    @(negedge clk);

    run_scan(0, 16'h8001, 1'b0, 1'b0, 1'b0);
    chk("r8001_result", 32'(result[0]), 32'h8001);
    chk("r8001_mismatch", 32'(mismatch[0]), 32'd0);
    run_scan(1, 16'hA5A5, 1'b0, 1'b0, 1'b0);
    chk("rA5A5_result", 32'(result[1]), 32'hA5A5);
    run_scan(0, 16'hFFFF, 1'b1, 1'b0, 1'b0);
    chk("forced0_result", 32'(result[0]), 32'h0000);
    chk("forced0_mismatch", 32'(mismatch[0]), 32'd1);
    run_scan(1, 16'hFFFF, 1'b1, 1'b0, 1'b0);
    force0 = 2'b00;
    run_scan(0, 16'h00FF, 1'b0, 1'b0, 1'b1);
    chk("midchg_result", 32'(result[0]), 32'h00FF);
    repeat (5) @(negedge clk);
    chk("hold_sel", 32'(mux_sel[0]), 32'd15);
    chk("hold_result", 32'(result[0]), 32'h00FF);
    chk("hold_mux_in", 32'(mux_in[0]), 32'h00FF);

    // Start held high for 40 edges: scans accepted at a, a+18, a+36.
    data[0] = 16'h3C5A;
    a = cyc + 1;
    push_scan(0, a, 16'h3C5A, 1'b0, 16);
    push_scan(0, a + 18, 16'h3C5A, 1'b0, 16);
    push_scan(0, a + 36, 16'h3C5A, 1'b0, 16);
    start[0] = 1'b1;
    busy_low = 0;
    @(negedge clk);
    while (cyc < a + 39) begin
      if (!busy[0]) busy_low++;
      @(negedge clk);
    end
    start[0] = 1'b0;
    chk("held_busy_low_cycles", 32'(busy_low), 32'd2);
    while (cyc < a + 56) @(negedge clk);
    chk("held_qempty", 32'(q.size()), 32'd0);

    // Reset on the 8th sample edge aborts the scan with no done.
    data[0] = 16'hF0F0;
    a = cyc + 1;
    push_scan(0, a, 16'hF0F0, 1'b0, 7);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    while (cyc < a + 7) @(negedge clk);
    rst[0] = 1'b1;
    @(negedge clk);
    check_zero(0, "abort");
    rst[0] = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_no_done", 32'(done[0]), 32'd0);
    chk("abort_qempty", 32'(q.size()), 32'd0);
    run_scan(0, 16'h1234, 1'b0, 1'b0, 1'b0);

    for (int k = 0; k < 12; k++) begin
      int g;
      g = int'($urandom_range(0, 1));
      run_scan(g, 16'($urandom), ($urandom_range(0, 3) == 0), 1'b1, 1'($urandom_range(0, 1)));
      force0[g] = 1'b0;
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    chk("final_qempty", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
